// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar slave-side arbitration logic.
// Holds the master index constants, the arbiter state enum and a small
// helper that turns a master index into its one-hot grant vector.
// No ports (package).
package xbar_pkg;

  localparam logic MASTER0 = 1'b0;
  localparam logic MASTER1 = 1'b1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arbState_e;

  // One-hot grant vector for a master index (bit0 = master 0).
  function automatic logic [1:0] masterOneHot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/slave_arbiter_if.sv
// Bus bundle between the two masters and one slave arbiter.
// Signals:
//   req    [1:0] per-master request level (bit0 = master 0)
//   ack          one-cycle completion strobe from the slave
//   gnt    [1:0] one-hot grant
//   sel          read/write mux select (0 = master 0, 1 = master 1)
//   busy         high while a grant is active
//   tmo          one-cycle pulse on watchdog release
//   tmo_id       master released by the watchdog, valid while tmo is high
// Modports:
//   slave  - the arbiter side (consumes req/ack, drives grant outputs)
//   master - the environment side (drives req/ack, observes grant outputs)
interface slave_arbiter_if;

  logic [1:0] req;
  logic       ack;
  logic [1:0] gnt;
  logic       sel;
  logic       busy;
  logic       tmo;
  logic       tmo_id;

  modport slave (
    input  req,
    input  ack,
    output gnt,
    output sel,
    output busy,
    output tmo,
    output tmo_id
  );

  modport master (
    output req,
    output ack,
    input  gnt,
    input  sel,
    input  busy,
    input  tmo,
    input  tmo_id
  );

endinterface

// File: rtl/arb_wdt.sv
// Grant watchdog for the slave arbiter.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   start     entering BUSY on the next edge; clears the counter
//   run       arbiter is currently BUSY
//   ack       slave completion strobe; an ack cycle never counts or expires
//   expire    combinational: this BUSY cycle is the one in which the counter
//             reaches TIMEOUT without an ack, so the grant must be released
//             on the coming edge
module arb_wdt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  input  logic ack,
  output logic expire
);

  localparam int CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] CntLast  = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // Counter register; holds the number of BUSY cycles seen without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Clear on grant, count every un-acked BUSY cycle, saturate at TIMEOUT
  // so the counter can never wrap back into a live range.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (run && !ack && (cnt_q != CntLimit)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // The increment that makes the counter equal TIMEOUT is the release point.
  assign expire = run && !ack && (cnt_q == CntLast);

endmodule

// File: rtl/slave_arbiter.sv
// Two-master round-robin arbiter guarding a single slave.
// Ports:
//   clk   single clock, all state changes on its rising edge
//   rst   asynchronous active-high reset
//   bus   slave_arbiter_if.slave bundle (req/ack in, gnt/sel/busy/tmo/tmo_id out)
// Parameter:
//   TIMEOUT  cycles a grant may wait for ack before forced release (2..255)
// Every output is a flop; grants are issued one cycle after a request is seen
// in IDLE and a release always returns to IDLE, which leaves at least one idle
// cycle between consecutive grants.
module slave_arbiter
  import xbar_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  slave_arbiter_if.slave        bus
);

  arbState_e  state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       tmo_q, tmo_d;
  logic       tmoId_q, tmoId_d;
  logic       lastGnt_q, lastGnt_d;

  logic       winner;
  logic       grantedReq;
  logic       releaseNow;
  logic       wdtStart;
  logic       wdtRun;
  logic       wdtExpire;

  // Round robin: a lone requester wins outright, a tie goes to the master
  // that was not granted last.
  always_comb begin
    winner = MASTER0;
    if (bus.req == 2'b11) begin
      winner = ~lastGnt_q;
    end else if (bus.req[1]) begin
      winner = MASTER1;
    end
  end

  // Release causes while BUSY: ack (also covers ack together with a req
  // drop), abort by the granted master, or watchdog expiry.
  assign grantedReq = bus.req[sel_q];
  assign releaseNow = bus.ack || !grantedReq || wdtExpire;

  assign wdtStart = (state_q == ARB_IDLE) && (bus.req != 2'b00);
  assign wdtRun   = (state_q == ARB_BUSY);

  arb_wdt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .start  (wdtStart),
    .run    (wdtRun),
    .ack    (bus.ack),
    .expire (wdtExpire)
  );

  // State and output registers. Reset leaves the pointer on master 1 so that
  // master 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= 2'b00;
      sel_q     <= MASTER0;
      busy_q    <= 1'b0;
      tmo_q     <= 1'b0;
      tmoId_q   <= MASTER0;
      lastGnt_q <= MASTER1;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      tmo_q     <= tmo_d;
      tmoId_q   <= tmoId_d;
      lastGnt_q <= lastGnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (bus.req != 2'b00) state_d = ARB_BUSY;
      ARB_BUSY: if (releaseNow)       state_d = ARB_IDLE;
      default:                        state_d = ARB_IDLE;
    endcase
  end

  // Next output values. sel is never cleared on release so the data mux
  // keeps pointing at the last granted master while idle.
  always_comb begin
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    tmo_d     = 1'b0;
    tmoId_d   = tmoId_q;
    lastGnt_d = lastGnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (bus.req != 2'b00) begin
          gnt_d     = masterOneHot(winner);
          sel_d     = winner;
          busy_d    = 1'b1;
          lastGnt_d = winner;
        end
      end
      ARB_BUSY: begin
        if (releaseNow) begin
          gnt_d  = 2'b00;
          busy_d = 1'b0;
          // Only a pure watchdog release reports a timeout; ack or abort win.
          if (!bus.ack && grantedReq && wdtExpire) begin
            tmo_d   = 1'b1;
            tmoId_d = sel_q;
          end
        end
      end
      default: begin
        gnt_d  = 2'b00;
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.gnt    = gnt_q;
  assign bus.sel    = sel_q;
  assign bus.busy   = busy_q;
  assign bus.tmo    = tmo_q;
  assign bus.tmo_id = tmoId_q;

endmodule

// File: tb/tb_slave_arbiter.sv
// Randomized scoreboard bench for slave_arbiter (TIMEOUT = 4).
// The stimulus process plans whole transactions (who requests, how the grant
// ends and after how many cycles), predicts grant and release events from the
// arbitration rules and queues them; a monitor on the falling edge pops and
// compares whenever the grant vector rises or falls.
module tb_slave_arbiter;

  localparam int Tmo = 4;

  typedef struct {
    bit         isGrant;
    logic [1:0] gnt;
    bit         sel;
    bit         tmo;
    bit         tmoId;
    int         cyc;
  } expEvt_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  expEvt_t    expQ[$];
  expEvt_t    mon;
  logic [1:0] prevGnt = 2'b00;
  bit         selModel = 1'b0;

  bit         lastModel;
  logic [1:0] pendingMask;

  slave_arbiter_if bus ();

  slave_arbiter #(
    .TIMEOUT(Tmo)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Rising-edge counter used to time-stamp expected events.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: on each falling edge, compare grant rises and falls against the
  // queued predictions and check that nothing changes in between.
  always @(negedge clk) begin
    if (rst) begin
      prevGnt  = 2'b00;
      selModel = 1'b0;
    end else begin
      if (prevGnt == 2'b00 && bus.gnt != 2'b00) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedGrant", int'(bus.gnt), 0);
        end else begin
          mon = expQ.pop_front();
          checkOutput("evtIsGrant", 1, int'(mon.isGrant));
          checkOutput("gntValue", int'(bus.gnt), int'(mon.gnt));
          checkOutput("gntSel", int'(bus.sel), int'(mon.sel));
          checkOutput("gntBusy", int'(bus.busy), 1);
          checkOutput("gntCycle", cyc, mon.cyc);
          selModel = mon.sel;
        end
      end else if (prevGnt != 2'b00 && bus.gnt == 2'b00) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedRelease", int'(prevGnt), 0);
        end else begin
          mon = expQ.pop_front();
          checkOutput("evtIsRelease", 0, int'(mon.isGrant));
          checkOutput("relBusy", int'(bus.busy), 0);
          checkOutput("relTmo", int'(bus.tmo), int'(mon.tmo));
          if (mon.tmo) checkOutput("relTmoId", int'(bus.tmo_id), int'(mon.tmoId));
          checkOutput("relSelHold", int'(bus.sel), int'(selModel));
          checkOutput("relCycle", cyc, mon.cyc);
        end
      end else begin
        checkOutput("tmoQuiet", int'(bus.tmo), 0);
        checkOutput("busyVsGnt", int'(bus.busy), int'(bus.gnt != 2'b00));
        checkOutput("selStable", int'(bus.sel), int'(selModel));
        if (bus.gnt != 2'b00) checkOutput("gntStable", int'(bus.gnt), int'(prevGnt));
      end
      prevGnt = bus.gnt;
    end
  end

  // One planned transaction, entered on a falling edge with the arbiter idle.
  // forcePat = 0 picks a random request pattern; outstanding requests of a
  // master still waiting are always kept.
  task automatic applyStimulus(input logic [1:0] forcePat);
    logic [1:0] pat;
    int         mode;
    int         d;
    int         g;
    bit         w;
    expEvt_t    e;

    if (forcePat == 2'b00 && pendingMask == 2'b00 && $urandom_range(0, 2) == 0) begin
      bus.req = 2'b00;
      bus.ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      bus.ack = 1'b0;
    end

    pat = (forcePat != 2'b00) ? forcePat : 2'($urandom_range(1, 3));
    pat = pat | pendingMask;

    if (pat == 2'b11) w = ~lastModel;
    else              w = pat[1];
    lastModel = w;

    mode = $urandom_range(0, 2);
    case (mode)
      0:       d = $urandom_range(1, Tmo);
      1:       d = $urandom_range(1, Tmo - 1);
      default: d = Tmo;
    endcase

    bus.req = pat;
    g = cyc + 1;

    e.isGrant = 1'b1;
    e.gnt     = w ? 2'b10 : 2'b01;
    e.sel     = w;
    e.tmo     = 1'b0;
    e.tmoId   = 1'b0;
    e.cyc     = g;
    expQ.push_back(e);
    e.isGrant = 1'b0;
    e.gnt     = 2'b00;
    e.tmo     = (mode == 2);
    e.tmoId   = w;
    e.cyc     = g + d;
    expQ.push_back(e);

    @(negedge clk);
    if (d > 1 && pat != 2'b11 && $urandom_range(0, 1) == 1) bus.req[1 - int'(w)] = 1'b1;
    repeat (d - 1) @(negedge clk);
    if (mode == 0) bus.ack = 1'b1;
    if (mode == 1) bus.req[w] = 1'b0;
    @(negedge clk);
    bus.ack    = 1'b0;
    bus.req[w] = 1'b0;
    pendingMask = bus.req;
  endtask

  // Main sequence: reset checks, random transactions, then a reset that
  // lands in the middle of a grant.
  initial begin
    bus.req = 2'b00;
    bus.ack = 1'b0;
    rst     = 1'b1;
    lastModel   = 1'b1;
    pendingMask = 2'b00;
    repeat (3) @(negedge clk);
    checkOutput("rstGnt", int'(bus.gnt), 0);
    checkOutput("rstSel", int'(bus.sel), 0);
    checkOutput("rstBusy", int'(bus.busy), 0);
    checkOutput("rstTmo", int'(bus.tmo), 0);
    checkOutput("rstTmoId", int'(bus.tmo_id), 0);
    rst = 1'b0;

    applyStimulus(2'b11);
    for (int t = 0; t < 60; t++) applyStimulus(2'b00);

    begin : midReset
      logic [1:0] pat;
      bit         w;
      expEvt_t    e;
      pat = 2'b10 | pendingMask;
      if (pat == 2'b11) w = ~lastModel;
      else              w = pat[1];
      bus.req   = pat;
      e.isGrant = 1'b1;
      e.gnt     = w ? 2'b10 : 2'b01;
      e.sel     = w;
      e.tmo     = 1'b0;
      e.tmoId   = 1'b0;
      e.cyc     = cyc + 1;
      expQ.push_back(e);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("midRstGnt", int'(bus.gnt), 0);
      checkOutput("midRstBusy", int'(bus.busy), 0);
      checkOutput("midRstTmo", int'(bus.tmo), 0);
      checkOutput("midRstSel", int'(bus.sel), 0);
      bus.req = 2'b00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      lastModel   = 1'b1;
      pendingMask = 2'b00;
    end

    applyStimulus(2'b11);
    applyStimulus(2'b11);
    bus.req = 2'b00;
    repeat (Tmo + 3) @(negedge clk);
    checkOutput("queueDrained", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
